// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffered 8N1 (optional parity) UART transmitter.
// Bytes are queued in a power-of-two circular FIFO. The frame engine runs on an
// internal tick that is 16x the bit rate and drains the FIFO with no idle gap
// between queued frames.
module uart_tx_buf #(
    parameter int unsigned CLK_DIV    = 326,
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  busy,
    output logic                  tx
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W  = DEPTH_LOG2;
    localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
    localparam int unsigned TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SUB_W  = 4;
    localparam int unsigned BIT_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Oversample tick
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    assign tick = (tick_cnt == TICK_W'(CLK_DIV - 1));

    // Free-running divider; wraps to zero on the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_d;
    logic [7:0]       head;
    logic             push;
    logic             pop;

    // full is the registered flag, so a write while full is dropped even
    // if the frame engine pops in the same cycle.
    assign push    = wr_en && !full;
    assign head    = mem[rd_ptr];
    assign count_d = count + CNT_W'(push) - CNT_W'(pop);

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_d;
            full     <= (count_d == CNT_W'(DEPTH));
            empty    <= (count_d == '0);
            overflow <= overflow | (wr_en & full);
        end
    end

    // ------------------------------------------------------------------
    // Frame engine
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_d;
    logic [7:0]       shift;
    logic [7:0]       shift_d;
    logic [SUB_W-1:0] sub;
    logic [SUB_W-1:0] sub_d;
    logic [BIT_W-1:0] bitn;
    logic [BIT_W-1:0] bit_d;
    logic             par;
    logic             par_d;
    logic             tx_d;
    logic             busy_d;
    logic             last_sub;

    assign last_sub = (sub == SUB_W'(15));

    // State and datapath registers; tx and busy are registered from their next values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            shift <= '0;
            sub   <= '0;
            bitn  <= '0;
            par   <= 1'b0;
            tx    <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            shift <= shift_d;
            sub   <= sub_d;
            bitn  <= bit_d;
            par   <= par_d;
            tx    <= tx_d;
            busy  <= busy_d;
        end
    end

    // Next-state, pop request and next line level; everything advances only on a tick.
    always_comb begin
        state_d = state;
        shift_d = shift;
        sub_d   = sub;
        bit_d   = bitn;
        par_d   = par;
        pop     = 1'b0;

        if (tick) begin
            case (state)
                S_IDLE: begin
                    pop = !empty;
                end
                S_START: begin
                    if (last_sub) begin
                        sub_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        sub_d = sub + SUB_W'(1);
                    end
                end
                S_DATA: begin
                    if (last_sub) begin
                        sub_d   = '0;
                        shift_d = {1'b0, shift[7:1]};
                        if (bitn == BIT_W'(7)) begin
                            bit_d   = '0;
                            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bitn + BIT_W'(1);
                        end
                    end else begin
                        sub_d = sub + SUB_W'(1);
                    end
                end
                S_PARITY: begin
                    if (last_sub) begin
                        sub_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        sub_d = sub + SUB_W'(1);
                    end
                end
                S_STOP: begin
                    if (last_sub) begin
                        sub_d = '0;
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        sub_d = sub + SUB_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Loading a new byte always restarts the frame from the start bit.
            if (pop) begin
                state_d = S_START;
                shift_d = head;
                sub_d   = '0;
                bit_d   = '0;
                par_d   = (^head) ^ (PARITY_ODD != 0);
            end
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: three instances (no parity, odd parity, even parity).
// Stimulus pushes expected frames into a scoreboard queue; per-instance monitors
// decode tx and compare against the queue head.
module tb_uart_tx_buf;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned DL2      = 3;
    localparam int          BIT_CLKS = 16 * CLK_DIV;

    typedef struct {
        int         idx;
        logic [7:0] data;
        bit         b2b;
        bit         chk_lat;
        int         wr_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] wr_en_v;
    logic [7:0] wr_data_a [3];
    logic [2:0] full_v;
    logic [2:0] empty_v;
    logic [2:0] ovf_v;
    logic [2:0] busy_v;
    logic [2:0] tx_v;
    logic [DL2:0] count_a [3];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_buf #(.CLK_DIV(CLK_DIV), .DEPTH_LOG2(DL2), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_v[0]), .wr_data(wr_data_a[0]),
        .full(full_v[0]), .empty(empty_v[0]), .count(count_a[0]),
        .overflow(ovf_v[0]), .busy(busy_v[0]), .tx(tx_v[0])
    );

    uart_tx_buf #(.CLK_DIV(CLK_DIV), .DEPTH_LOG2(DL2), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_v[1]), .wr_data(wr_data_a[1]),
        .full(full_v[1]), .empty(empty_v[1]), .count(count_a[1]),
        .overflow(ovf_v[1]), .busy(busy_v[1]), .tx(tx_v[1])
    );

    uart_tx_buf #(.CLK_DIV(CLK_DIV), .DEPTH_LOG2(DL2), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_v[2]), .wr_data(wr_data_a[2]),
        .full(full_v[2]), .empty(empty_v[2]), .count(count_a[2]),
        .overflow(ovf_v[2]), .busy(busy_v[2]), .tx(tx_v[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Single-cycle write at the next edge; call at a negedge, returns at the following negedge.
    task automatic wr(input int idx, input logic [7:0] d, input bit b2b, input bit lat, input bit accept);
        exp_t e;
        wr_en_v[idx]   = 1'b1;
        wr_data_a[idx] = d;
        @(negedge clk);
        wr_en_v[idx] = 1'b0;
        if (accept) begin
            e.idx     = idx;
            e.data    = d;
            e.b2b     = b2b;
            e.chk_lat = lat;
            e.wr_cyc  = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_tx_low(input int idx, input int budget, output int start_c);
        int n;
        n = 0;
        while (tx_v[idx] !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_v[idx] !== 1'b0) begin
            errors++;
            $display("FAIL start_timeout dut%0d: tx=%b after %0d clocks, expected 0", idx, tx_v[idx], n);
        end
        start_c = cyc;
    endtask

    task automatic wait_busy_low(input int idx, input int budget, output int fall_c);
        int n;
        n = 0;
        while (busy_v[idx] !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_v[idx] !== 1'b0) begin
            errors++;
            $display("FAIL busy_timeout dut%0d: busy=%b after %0d clocks, expected 0", idx, busy_v[idx], n);
        end
        fall_c = cyc;
    endtask

    task automatic frame_len_check(input int idx, input string name, input int exp_len);
        int s;
        int f;
        wait_tx_low(idx, CLK_DIV + 2, s);
        chk({name, "_empty_at_pop"}, int'(empty_v[idx]), 1);
        chk({name, "_count_at_pop"}, int'(count_a[idx]), 0);
        chk({name, "_busy_in_frame"}, int'(busy_v[idx]), 1);
        wait_busy_low(idx, exp_len + 100, f);
        chk({name, "_frame_len"}, f - s, exp_len);
    endtask

    task automatic wait_drain(input int idx, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_v[idx] !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_busy", int'(busy_v[idx]), 0);
    endtask

    // Decodes frames on one instance's tx and scores them against the queue head.
    task automatic monitor(input int idx);
        int          nbits;
        int          last_start;
        bit          have_last;
        logic [10:0] bits;
        bit          stable;
        bit          aborted;
        int          start_c;
        int          lat;
        exp_t        e;
        nbits     = (idx == 0) ? 10 : 11;
        have_last = 1'b0;
        last_start = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                have_last = 1'b0;
                continue;
            end
            if (tx_v[idx] !== 1'b0) continue;
            start_c = cyc;
            bits    = '0;
            stable  = 1'b1;
            aborted = 1'b0;
            for (int c = 0; c < nbits * BIT_CLKS; c++) begin
                if (c != 0) @(negedge clk);
                if (rst_n !== 1'b1) begin
                    aborted = 1'b1;
                    break;
                end
                if (c % BIT_CLKS == 0) bits[c / BIT_CLKS] = tx_v[idx];
                else if (tx_v[idx] !== bits[c / BIT_CLKS]) stable = 1'b0;
            end
            if (aborted) begin
                have_last = 1'b0;
                continue;
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame dut%0d: got frame data 0x%02h at cycle %0d, expected no frame",
                         idx, bits[8:1], start_c);
            end else begin
                e = exp_q.pop_front();
                chk("frame_dut", idx, e.idx);
                chk($sformatf("frame_data_dut%0d", idx), int'(bits[8:1]), int'(e.data));
                chk($sformatf("bit_width_dut%0d", idx), int'(stable), 1);
                chk($sformatf("stop_bit_dut%0d", idx), int'(bits[nbits - 1]), 1);
                if (nbits == 11)
                    chk($sformatf("parity_bit_dut%0d", idx), int'(bits[9]),
                        int'((^e.data) ^ (idx == 1)));
                if (e.chk_lat) begin
                    lat = start_c - e.wr_cyc;
                    checks++;
                    if (lat < 1 || lat > int'(CLK_DIV)) begin
                        errors++;
                        $display("FAIL start_latency dut%0d: got %0d clocks, expected 1..%0d", idx, lat, CLK_DIV);
                    end
                end
                if (e.b2b) begin
                    if (have_last) begin
                        chk($sformatf("b2b_gap_dut%0d", idx), start_c - last_start, nbits * BIT_CLKS);
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL b2b_gap dut%0d: got no preceding frame, expected contiguous frame", idx);
                    end
                end
            end
            last_start = start_c;
            have_last  = 1'b1;
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  s;
        bit  idle_ok;

        rst_n   = 1'b0;
        wr_en_v = '0;
        for (int i = 0; i < 3; i++) wr_data_a[i] = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values and a quiet line.
        chk("reset_tx", int'(tx_v[0]), 1);
        chk("reset_empty", int'(empty_v[0]), 1);
        chk("reset_full", int'(full_v[0]), 0);
        chk("reset_count", int'(count_a[0]), 0);
        chk("reset_busy", int'(busy_v[0]), 0);
        chk("reset_overflow", int'(ovf_v[0]), 0);
        idle_ok = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1) idle_ok = 1'b0;
        end
        chk("idle_tx_stable", int'(idle_ok), 1);

        // Single byte.
        wr(0, 8'h55, 1'b0, 1'b1, 1'b1);
        chk("single_busy_after_write", int'(busy_v[0]), 1);
        chk("single_count_after_write", int'(count_a[0]), 1);
        frame_len_check(0, "single", 10 * BIT_CLKS);
        wait_drain(0, 200);

        // Back-to-back.
        wr(0, 8'hA3, 1'b0, 1'b1, 1'b1);
        wr(0, 8'h0F, 1'b1, 1'b0, 1'b1);
        wait_drain(0, 3 * 10 * BIT_CLKS);

        // Overflow while a frame is in flight.
        wr(0, 8'h01, 1'b0, 1'b1, 1'b1);
        wait_tx_low(0, CLK_DIV + 2, s);
        for (int i = 0; i < 8; i++) begin
            wr(0, 8'(8'h10 + i), 1'b1, 1'b0, 1'b1);
            if (i == 6) begin
                chk("ovf_count_7", int'(count_a[0]), 7);
                chk("ovf_full_at_7", int'(full_v[0]), 0);
            end
        end
        chk("ovf_full_at_8", int'(full_v[0]), 1);
        chk("ovf_count_8", int'(count_a[0]), 8);
        chk("ovf_no_overflow_yet", int'(ovf_v[0]), 0);
        wr(0, 8'h18, 1'b0, 1'b0, 1'b0);
        chk("ovf_overflow_set", int'(ovf_v[0]), 1);
        chk("ovf_count_held", int'(count_a[0]), 8);
        wait_drain(0, 10 * 10 * BIT_CLKS);
        chk("ovf_sticky", int'(ovf_v[0]), 1);
        chk("ovf_empty_after_drain", int'(empty_v[0]), 1);

        // Parity, odd then even.
        wr(1, 8'h07, 1'b0, 1'b1, 1'b1);
        frame_len_check(1, "parity_odd", 11 * BIT_CLKS);
        wait_drain(1, 200);
        wr(2, 8'h07, 1'b0, 1'b1, 1'b1);
        frame_len_check(2, "parity_even", 11 * BIT_CLKS);
        wait_drain(2, 200);

        // Reset during data bit 3 with two bytes queued.
        wr(0, 8'hC3, 1'b0, 1'b1, 1'b1);
        wr(0, 8'h11, 1'b1, 1'b0, 1'b1);
        wr(0, 8'h22, 1'b1, 1'b0, 1'b1);
        wait_tx_low(0, CLK_DIV + 2, s);
        repeat (BIT_CLKS + 3 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        chk("midframe_tx_bit3", int'(tx_v[0]), 0);
        chk("midframe_count", int'(count_a[0]), 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx", int'(tx_v[0]), 1);
        chk("async_reset_count", int'(count_a[0]), 0);
        chk("async_reset_empty", int'(empty_v[0]), 1);
        chk("async_reset_busy", int'(busy_v[0]), 0);
        chk("async_reset_overflow", int'(ovf_v[0]), 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle_ok = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) idle_ok = 1'b0;
        end
        chk("post_reset_quiet", int'(idle_ok), 1);
        wr(0, 8'h5A, 1'b0, 1'b1, 1'b1);
        wait_drain(0, 2 * 10 * BIT_CLKS);

        repeat (10) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Buffered UART transmitter for the MIPS SoC's serial port. The CPU or a test controller writes bytes into an internal FIFO without waiting on the line. The block serialises them as 8-bit LSB-first frames: optional parity, one stop bit, 16x oversampled timing generated internally from the system clock. It sits next to `uartrx` as the transmit half of the console path.

## Interface
Parameters:
- CLK_DIV, 326: system clocks per 16x-oversample tick (50 MHz / (16 × 9600) ≈ 326).
- DEPTH_LOG2, 3: FIFO depth = 2^DEPTH_LOG2 entries (default 8).
- PARITY_EN, 0: 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0: 1 selects odd parity, 0 selects even. Ignored when PARITY_EN = 0.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe; one byte per cycle.
- wr_data  in  8  byte to enqueue.
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  DEPTH_LOG2+1  current FIFO occupancy.
- overflow  out  1  sticky; set when a write is dropped. Cleared only by reset.
- busy  out  1  high when state ≠ IDLE or empty = 0.
- tx  out  1  serial line, registered; idles high.

## Operation
**Tick generator**
- Free-running counter 0..CLK_DIV-1, starting from reset.
- `tick` is an internal one-clock pulse when the counter is at CLK_DIV-1; the counter then wraps to 0.
- One bit period = 16 ticks.

**FIFO**
- Circular buffer; read and write pointers wrap modulo depth.
- A write is accepted when wr_en = 1 and full = 0, with full sampled *before* any same-cycle pop.
  - A write while full is dropped, even if a pop occurs in the same cycle, and it sets overflow.
- Simultaneous accepted write and pop: count is unchanged.
- A pop occurs only on the FSM transition into START.

**FSM states: IDLE, START, DATA, PARITY, STOP**
- IDLE: tx = 1. On a tick with empty = 0: pop the head into the shift register, clear the sub-tick and bit counters, go to START.
- START: tx = 0 for 16 ticks, then go to DATA.
- DATA: tx = shift[0] for 16 ticks per bit, shifting right after each bit. After 8 bits, go to PARITY if PARITY_EN = 1, otherwise to STOP.
- PARITY: tx = (^byte) ^ PARITY_ODD for 16 ticks, then go to STOP.
- STOP: tx = 1 for 16 ticks. At the final tick:
  - if empty = 0, pop and go directly to START (zero idle gap between frames);
  - otherwise go to IDLE.

**Reset (rst_n low, at any time including mid-frame)**
- Immediately: tx = 1, state = IDLE, FIFO flushed.
- Outputs: count = 0, empty = 1, full = 0, overflow = 0, busy = 0.
- Tick counter = 0; the in-flight byte is lost.

## Timing
- Reset values: tx = 1, empty = 1, full = 0, count = 0, overflow = 0, busy = 0.
- Write at edge n updates count, empty and full at edge n (visible in cycle n+1).
- The earliest pop is at the first tick edge ≥ n+1. tx falls at that edge, so write-to-start-bit latency is 1 to CLK_DIV clocks.
- busy rises at edge n together with empty.
- Frame length: (10 + PARITY_EN) × 16 × CLK_DIV clocks. Every bit edge of tx is aligned to a tick edge.
- Back-to-back frames: the next start bit begins exactly 16 × CLK_DIV clocks after the previous stop bit began.
- busy falls at the same edge the FSM enters IDLE with an empty FIFO.
- overflow rises at the edge of the dropped write.

## Test plan
Default bench parameters: CLK_DIV = 4 (bit = 64 clocks), DEPTH_LOG2 = 3, PARITY_EN = 0.
1. **Reset:** hold rst_n low for 5 clocks, then release → tx = 1, empty = 1, full = 0, count = 0, busy = 0, overflow = 0. No transitions on tx for 1000 clocks.
2. **Single byte:** write 0x55 →
   - tx falls within 4 clocks;
   - bit sequence 0,1,0,1,0,1,0,1,0,1, each exactly 64 clocks;
   - frame = 640 clocks;
   - empty = 1 from the pop; busy = 0 after the stop bit.
3. **Back-to-back:** write 0xA3 then 0x0F on consecutive cycles → two contiguous 640-clock frames with data LSB-first 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0. No idle gap; the second start bit begins 64 clocks after the first stop bit begins.
4. **Overflow:** during a frame in flight, write 9 bytes 0x10..0x18 on consecutive cycles →
   - full = 1 after the 8th write; 0x18 is dropped; overflow = 1;
   - frames 0x10..0x17 follow in order; overflow stays 1 until reset.
5. **Parity:** PARITY_EN = 1, PARITY_ODD = 1, write 0x07 → parity bit 0. With PARITY_ODD = 0 → parity bit 1. Frame = 704 clocks.
6. **Reset mid-frame:** assert rst_n low during data bit 3, with 2 bytes queued →
   - tx = 1 and count = 0 immediately, without waiting for clk;
   - after release, no frame is sent until a new write.
